// File: rtl/writeback_stage.sv
`timescale 1ns/1ps
// writeback_stage: MEM/WB pipeline register, register-file write port,
// WB-to-ID forwarding match and a saturating retired-instruction counter.
module writeback_stage #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic                  mem_regwrite,
    input  logic                  mem_memtoreg,
    input  logic [4:0]            mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_alu_result,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [4:0]            id_rn,
    input  logic [4:0]            id_rb,
    output logic                  wb_regwrite,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  fwd_a,
    output logic                  fwd_b,
    output logic [CNT_WIDTH-1:0]  retire_count
);

    localparam logic [4:0] XZR = 5'd31;

    logic                  valid_q,    valid_d;
    logic                  regwrite_q, regwrite_d;
    logic                  memtoreg_q, memtoreg_d;
    logic [4:0]            rd_q,       rd_d;
    logic [DATA_WIDTH-1:0] alu_q,      alu_d;
    logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
    logic [CNT_WIDTH-1:0]  retire_count_q, retire_count_d;
    logic                  retire;

    // Next-state for MEM/WB: flush inserts a bubble, stall holds, else capture.
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        rd_d       = rd_q;
        alu_d      = alu_q;
        rdata_d    = rdata_q;
        if (flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
        end else if (!stall) begin
            valid_d    = mem_valid;
            regwrite_d = mem_regwrite;
            memtoreg_d = mem_memtoreg;
            rd_d       = mem_rd;
            alu_d      = mem_alu_result;
            rdata_d    = mem_read_data;
        end
    end

    // Retirement happens when a valid held instruction leaves WB; counter saturates.
    always_comb begin
        retire         = valid_q && (!stall || flush);
        retire_count_d = retire_count_q;
        if (retire && (retire_count_q != '1)) begin
            retire_count_d = retire_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // MEM/WB register and retire counter, asynchronously cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q        <= 1'b0;
            regwrite_q     <= 1'b0;
            memtoreg_q     <= 1'b0;
            rd_q           <= '0;
            alu_q          <= '0;
            rdata_q        <= '0;
            retire_count_q <= '0;
        end else begin
            valid_q        <= valid_d;
            regwrite_q     <= regwrite_d;
            memtoreg_q     <= memtoreg_d;
            rd_q           <= rd_d;
            alu_q          <= alu_d;
            rdata_q        <= rdata_d;
            retire_count_q <= retire_count_d;
        end
    end

    // Register-file write port and forwarding match, from registered state only.
    always_comb begin
        wb_regwrite  = valid_q && regwrite_q && (rd_q != XZR);
        wb_rd        = rd_q;
        wb_data      = memtoreg_q ? rdata_q : alu_q;
        fwd_a        = wb_regwrite && (rd_q == id_rn);
        fwd_b        = wb_regwrite && (rd_q == id_rb);
        retire_count = retire_count_q;
    end

endmodule

// File: tb/tb_writeback_stage.sv
`timescale 1ns/1ps
// Testbench for writeback_stage: table-driven vectors through a scoreboard
// queue, plus hand-written stall, flush, saturation and reset sequences.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, mem_regwrite, mem_memtoreg;
    logic [4:0]  mem_rd;
    logic [63:0] mem_alu_result, mem_read_data;
    logic        stall, flush;
    logic [4:0]  id_rn, id_rb;

    logic        wb_regwrite, fwd_a, fwd_b;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic [31:0] retire_count;

    logic        s_wb_regwrite, s_fwd_a, s_fwd_b;
    logic [4:0]  s_wb_rd;
    logic [63:0] s_wb_data;
    logic [3:0]  s_retire_count;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    writeback_stage u_dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
        .mem_rd(mem_rd), .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
        .stall(stall), .flush(flush), .id_rn(id_rn), .id_rb(id_rb),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .retire_count(retire_count)
    );

    writeback_stage #(.DATA_WIDTH(64), .CNT_WIDTH(4)) u_sat (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
        .mem_rd(mem_rd), .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
        .stall(stall), .flush(flush), .id_rn(id_rn), .id_rb(id_rb),
        .wb_regwrite(s_wb_regwrite), .wb_rd(s_wb_rd), .wb_data(s_wb_data),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .retire_count(s_retire_count)
    );

    typedef struct {
        logic        v, rw, m2r;
        logic [4:0]  rd;
        logic [63:0] alu, rdata;
        logic [4:0]  rn, rb;
        logic        e_rw;
        logic [63:0] e_data;
        logic        e_fa, e_fb;
        int          e_cnt;
    } vec_t;

    vec_t tbl[8];
    vec_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_mem(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                             input logic [63:0] alu, input logic [63:0] rdata);
        mem_valid      = v;
        mem_regwrite   = rw;
        mem_memtoreg   = m2r;
        mem_rd         = rd;
        mem_alu_result = alu;
        mem_read_data  = rdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive_mem(1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vec_t cur;
        int   prior;

        //           v     rw    m2r   rd     alu                     rdata                   rn     rb     e_rw  e_data                  e_fa  e_fb  cnt
        tbl[0] = '{1'b1, 1'b1, 1'b0, 5'd5,  64'h1234,               64'h9999,               5'd5,  5'd6,  1'b1, 64'h1234,               1'b1, 1'b0, 0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 5'd31, 64'h40,                 64'hDEADBEEF,           5'd31, 5'd31, 1'b0, 64'hDEADBEEF,           1'b0, 1'b0, 0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 5'd7,  64'h77,                 64'h0,                  5'd7,  5'd8,  1'b1, 64'h77,                 1'b1, 1'b0, 0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 5'd7,  64'h77,                 64'h0,                  5'd7,  5'd7,  1'b1, 64'h77,                 1'b1, 1'b1, 0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 5'd9,  64'h55,                 64'h66,                 5'd9,  5'd9,  1'b0, 64'h55,                 1'b0, 1'b0, 0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 5'd10, 64'hAA,                 64'hBB,                 5'd10, 5'd10, 1'b0, 64'hAA,                 1'b0, 1'b0, 0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 5'd0,  64'h1,                  64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd1,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 5'd30, 64'h8000_0000_0000_0001, 64'h2,                 5'd29, 5'd30, 1'b1, 64'h8000_0000_0000_0001, 1'b0, 1'b1, 0};

        // Reset state, with a valid write presented that must not be captured.
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        id_rn = 5'd0; id_rb = 5'd0;
        drive_mem(1'b1, 1'b1, 1'b0, 5'd0, 64'hABCD, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_regwrite", {63'd0, wb_regwrite}, 64'd0);
        check("rst_data",     wb_data,              64'd0);
        check("rst_fwd_a",    {63'd0, fwd_a},       64'd0);
        check("rst_fwd_b",    {63'd0, fwd_b},       64'd0);
        check("rst_count",    {32'd0, retire_count}, 64'd0);

        // Table vectors through the scoreboard.
        do_reset();
        prior = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_mem(tbl[i].v, tbl[i].rw, tbl[i].m2r, tbl[i].rd, tbl[i].alu, tbl[i].rdata);
            cur = tbl[i];
            cur.e_cnt = prior;
            if (tbl[i].v) prior++;
            sb.push_back(cur);
            @(posedge clk);
            #1;
            cur = sb.pop_front();
            id_rn = cur.rn;
            id_rb = cur.rb;
            #1;
            check($sformatf("vec%0d_regwrite", i), {63'd0, wb_regwrite}, {63'd0, cur.e_rw});
            check($sformatf("vec%0d_rd", i),       {59'd0, wb_rd},       {59'd0, cur.rd});
            check($sformatf("vec%0d_data", i),     wb_data,              cur.e_data);
            check($sformatf("vec%0d_fwd_a", i),    {63'd0, fwd_a},       {63'd0, cur.e_fa});
            check($sformatf("vec%0d_fwd_b", i),    {63'd0, fwd_b},       {63'd0, cur.e_fb});
            check($sformatf("vec%0d_count", i),    {32'd0, retire_count}, 64'(cur.e_cnt));
        end

        // Stall held three cycles while MEM inputs keep changing.
        do_reset();
        id_rn = 5'd3; id_rb = 5'd4;
        drive_mem(1'b1, 1'b1, 1'b0, 5'd3, 64'h3333, 64'h0);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            stall = 1'b1;
            drive_mem(1'b1, 1'b1, k[0], 5'(k + 10), 64'($urandom), 64'($urandom));
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_regwrite", k), {63'd0, wb_regwrite}, 64'd1);
            check($sformatf("stall%0d_rd", k),       {59'd0, wb_rd},       64'd3);
            check($sformatf("stall%0d_data", k),     wb_data,              64'h3333);
            check($sformatf("stall%0d_fwd_a", k),    {63'd0, fwd_a},       64'd1);
            check($sformatf("stall%0d_count", k),    {32'd0, retire_count}, 64'd0);
        end
        @(negedge clk);
        stall = 1'b0;
        drive_mem(1'b0, 1'b1, 1'b0, 5'd3, 64'h0, 64'h0);
        @(posedge clk);
        #1;
        check("unstall_regwrite", {63'd0, wb_regwrite}, 64'd0);
        check("unstall_count",    {32'd0, retire_count}, 64'd1);

        // Flush together with stall while holding a valid instruction.
        do_reset();
        drive_mem(1'b1, 1'b1, 1'b0, 5'd4, 64'h4444, 64'h0);
        @(posedge clk);
        #1;
        check("pre_flush_regwrite", {63'd0, wb_regwrite}, 64'd1);
        @(negedge clk);
        stall = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_regwrite", {63'd0, wb_regwrite}, 64'd0);
        check("flush_count",    {32'd0, retire_count}, 64'd1);
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk);
        #1;
        check("flush_bubble_count", {32'd0, retire_count}, 64'd1);
        @(negedge clk);
        flush = 1'b0;

        // Long run: 4-bit counter saturates at 15, 32-bit one keeps counting.
        do_reset();
        for (int n = 0; n < 21; n++) begin
            @(negedge clk);
            drive_mem(1'b1, 1'b1, 1'b0, 5'(n), 64'(n), 64'h0);
            @(posedge clk);
            if (n == 15) begin
                #1;
                check("sat_at_15", {60'd0, s_retire_count}, 64'd15);
            end
        end
        #1;
        check("sat_hold_count", {60'd0, s_retire_count}, 64'd15);
        check("wide_count_20",  {32'd0, retire_count},   64'd20);

        // Reset asserted between edges while stalling: in-flight instruction dropped.
        @(negedge clk);
        stall = 1'b1;
        id_rn = 5'd20;
        @(posedge clk);
        #1;
        check("held_not_counted", {32'd0, retire_count}, 64'd20);
        check("held_fwd_a",       {63'd0, fwd_a},        64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("midstall_rst_regwrite", {63'd0, wb_regwrite},    64'd0);
        check("midstall_rst_rd",       {59'd0, wb_rd},          64'd0);
        check("midstall_rst_data",     wb_data,                 64'd0);
        check("midstall_rst_fwd_a",    {63'd0, fwd_a},          64'd0);
        check("midstall_rst_count",    {32'd0, retire_count},   64'd0);
        check("midstall_rst_sat",      {60'd0, s_retire_count}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_regwrite", {63'd0, wb_regwrite},  64'd0);
        check("post_rst_data",     wb_data,               64'd0);
        check("post_rst_count",    {32'd0, retire_count}, 64'd0);
        @(negedge clk);
        stall = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, giving the width of the datapath and writeback data.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, giving the width of the retired-instruction counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_valid  input  1  the MEM stage holds a real instruction, not a bubble.
REQ-006 SHALL have port mem_regwrite  input  1  the MEM-stage instruction writes a register.
REQ-007 SHALL have port mem_memtoreg  input  1  writeback source select: 1 = load data, 0 = ALU result.
REQ-008 SHALL have port mem_rd  input  5  the MEM-stage destination register index.
REQ-009 SHALL have port mem_alu_result  input  DATA_WIDTH  the ALU result from MEM.
REQ-010 SHALL have port mem_read_data  input  DATA_WIDTH  the data-memory read data from MEM.
REQ-011 SHALL have port stall  input  1  hold the MEM/WB register.
REQ-012 SHALL have port flush  input  1  load a bubble into the MEM/WB register.
REQ-013 SHALL have port id_rn  input  5  the ID read-port A index.
REQ-014 SHALL have port id_rb  input  5  the ID read-port B index, taken after Reg2Loc selection.
REQ-015 SHALL have port wb_regwrite  output  1  the register-file write enable.
REQ-016 SHALL have port wb_rd  output  5  the register-file write index.
REQ-017 SHALL have port wb_data  output  DATA_WIDTH  the register-file write data.
REQ-018 SHALL have port fwd_a  output  1  WB is writing id_rn this cycle.
REQ-019 SHALL have port fwd_b  output  1  WB is writing id_rb this cycle.
REQ-020 SHALL have port retire_count  output  CNT_WIDTH  the count of instructions retired.

Function
REQ-021 SHALL hold the following in the MEM/WB register: valid_q, regwrite_q, memtoreg_q, rd_q, alu_q, rdata_q.
REQ-022 SHALL, at a rising edge with flush=1, clear valid_q and regwrite_q and leave the data fields don't-care; flush has priority over stall.
REQ-023 SHALL, at a rising edge with flush=0 and stall=1, leave every register field unchanged.
REQ-024 SHALL, at a rising edge with flush=0 and stall=0, capture every mem_* input, so the instruction has 1-cycle latency from MEM inputs to WB outputs.
REQ-025 SHALL drive wb_regwrite = valid_q AND regwrite_q AND (rd_q != 31); writes to X31/XZR are always suppressed.
REQ-026 SHALL drive wb_rd = rd_q and wb_data = memtoreg_q ? rdata_q : alu_q, combinationally from registered state only.
REQ-027 SHALL drive fwd_a = wb_regwrite AND (rd_q == id_rn), and fwd_b likewise against id_rb; both are combinational.
REQ-028 SHALL never assert fwd_a or fwd_b for index 31, even when id_rn or id_rb equals 31.
REQ-029 SHALL retire an instruction at a rising edge where valid_q=1 and (stall=0 OR flush=1), i.e. when the held instruction departs.
REQ-030 SHALL count a stalled instruction once only, at its departure edge, regardless of how many cycles it is held.
REQ-031 SHALL increment retire_count by 1 per retirement and saturate at all-ones with no wrap-around.
REQ-032 SHALL count bubbles (valid_q=0) as non-retirements.
REQ-033 SHALL, when mem_valid=0 is captured, produce wb_regwrite=0 regardless of mem_regwrite.

Reset
REQ-034 SHALL, while reset=1 and asynchronously, clear valid_q, regwrite_q, memtoreg_q, rd_q, alu_q, rdata_q and retire_count to 0.
REQ-035 SHALL hold wb_regwrite=0, fwd_a=0, fwd_b=0 and wb_data=0 from reset assertion until the first capturing edge after deassertion.
REQ-036 SHALL, on reset asserted mid-stall or mid-flush, discard the in-flight instruction without counting it.

Verification
REQ-037 SHALL be tested with: mem_valid=1, regwrite=1, memtoreg=0, rd=5, alu=0x1234 -> next cycle wb_regwrite=1, wb_rd=5, wb_data=0x1234, retire_count increments after the following edge.
REQ-038 SHALL be tested with: a load, memtoreg=1, rdata=0xDEADBEEF, alu=0x40, rd=31 -> wb_data=0xDEADBEEF, wb_regwrite=0; id_rn=31 -> fwd_a=0.
REQ-039 SHALL be tested with: WB holding rd=7 with write enabled, id_rn=7, id_rb=8 -> fwd_a=1, fwd_b=0; then id_rb=7 -> fwd_b=1.
REQ-040 SHALL be tested with: stall held 3 cycles with new mem_* inputs changing each cycle -> WB outputs unchanged, retire_count +1 total only after stall drops.
REQ-041 SHALL be tested with: stall=1 and flush=1 together while holding a valid instruction -> next cycle wb_regwrite=0, retire_count +1.
REQ-042 SHALL be tested with: retire_count preloaded near saturation via a long run at CNT_WIDTH=4, 20 retirements -> retire_count=15; reset pulsed mid-stall -> all outputs 0 immediately.
